// File: rtl/iiitb_tlc_phase_sched_if.sv
// Signal bundle between the intersection phase scheduler and its environment.
// The master side drives the road sensors and the pedestrian/emergency inputs
// and watches the lamps; the slave side is the scheduler itself.
interface iiitb_tlc_phase_sched_if;
  logic       sensor;
  logic       ped_req;
  logic       emerg;
  logic [2:0] light_highway;
  logic [2:0] light_farm;
  logic       ped_walk;
  logic       ped_wait;
  logic [2:0] phase;

  modport master (
    output sensor, ped_req, emerg,
    input  light_highway, light_farm, ped_walk, ped_wait, phase
  );

  modport slave (
    input  sensor, ped_req, emerg,
    output light_highway, light_farm, ped_walk, ped_wait, phase
  );
endinterface

// File: rtl/iiitb_tlc_phase_sched.sv
// Intersection phase scheduler: highway / farm road / pedestrian.
// Highway rests green; a farm vehicle or a latched pedestrian request earns a
// service after the minimum highway dwell. Every green leaves through yellow
// (vehicle phases) and an all-red clearance. Emergency holds the highway green.
//
// state | meaning
// ------+------------------------------------------------------------
// HG    | highway green, farm red; waits for min dwell then a request
// HY    | highway yellow
// AR_A  | all red before the granted phase (or back to HG on emergency)
// FG    | farm green
// FY    | farm yellow
// PW    | pedestrian walk, both roads red
// AR_B  | all red before returning to highway green
module iiitb_tlc_phase_sched #(
  parameter int T_MIN_GREEN  = 20,
  parameter int T_YELLOW     = 4,
  parameter int T_ALLRED     = 2,
  parameter int T_FARM_GREEN = 12,
  parameter int T_WALK       = 10,
  parameter int CNT_W        = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  iiitb_tlc_phase_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    S_HG   = 3'd0,
    S_HY   = 3'd1,
    S_AR_A = 3'd2,
    S_FG   = 3'd3,
    S_FY   = 3'd4,
    S_PW   = 3'd5,
    S_AR_B = 3'd6
  } state_t;

  typedef enum logic {
    G_FARM = 1'b0,
    G_PED  = 1'b1
  } grant_t;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  localparam logic [CNT_W-1:0] D_HG = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] D_Y  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] D_AR = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] D_FG = CNT_W'(T_FARM_GREEN - 1);
  localparam logic [CNT_W-1:0] D_PW = CNT_W'(T_WALK - 1);

  state_t           r_state;
  grant_t           r_grant;
  grant_t           r_last;
  logic [CNT_W-1:0] r_timer;
  logic             r_ped_wait;
  logic [2:0]       r_hw;
  logic [2:0]       r_fm;
  logic             r_walk;

  state_t           w_next_state;
  grant_t           w_grant_nxt;
  grant_t           w_last_nxt;
  logic             w_expired;
  logic [2:0]       w_hw_nxt;
  logic [2:0]       w_fm_nxt;
  logic             w_walk_nxt;

  // Reload value for the dwell timer when a state is entered.
  function automatic logic [CNT_W-1:0] f_dwell(input state_t s);
    case (s)
      S_HY, S_FY:     f_dwell = D_Y;
      S_AR_A, S_AR_B: f_dwell = D_AR;
      S_FG:           f_dwell = D_FG;
      S_PW:           f_dwell = D_PW;
      default:        f_dwell = D_HG;
    endcase
  endfunction

  assign w_expired = (r_timer == '0);

  // Next-state, grant arbitration and next-output decode.
  always_comb begin
    w_next_state = r_state;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    case (r_state)
      S_HG: begin
        if (w_expired && !bus.emerg && (bus.sensor || r_ped_wait)) begin
          w_next_state = S_HY;
          if (bus.sensor && r_ped_wait) begin
            // Both waiting: alternate away from whoever won the last tie.
            w_grant_nxt = (r_last == G_FARM) ? G_PED : G_FARM;
            w_last_nxt  = (r_last == G_FARM) ? G_PED : G_FARM;
          end else if (bus.sensor) begin
            w_grant_nxt = G_FARM;
          end else begin
            w_grant_nxt = G_PED;
          end
        end
      end
      S_HY:   if (w_expired) w_next_state = S_AR_A;
      S_AR_A: begin
        if (w_expired) begin
          if (bus.emerg)               w_next_state = S_HG;
          else if (r_grant == G_FARM)  w_next_state = S_FG;
          else                         w_next_state = S_PW;
        end
      end
      S_FG:   if (w_expired || bus.emerg) w_next_state = S_FY;
      S_FY:   if (w_expired) w_next_state = S_AR_B;
      S_PW:   if (w_expired || bus.emerg) w_next_state = S_AR_B;
      S_AR_B: if (w_expired) w_next_state = S_HG;
      default: w_next_state = S_HG;
    endcase

    w_hw_nxt   = L_RED;
    w_fm_nxt   = L_RED;
    w_walk_nxt = 1'b0;
    case (w_next_state)
      S_HG:    w_hw_nxt   = L_GRN;
      S_HY:    w_hw_nxt   = L_YEL;
      S_FG:    w_fm_nxt   = L_GRN;
      S_FY:    w_fm_nxt   = L_YEL;
      S_PW:    w_walk_nxt = 1'b1;
      default: ;
    endcase
  end

  // State, arbitration memory, dwell timer and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_HG;
      r_grant <= G_FARM;
      r_last  <= G_PED;
      r_timer <= D_HG;
      r_hw    <= L_GRN;
      r_fm    <= L_RED;
      r_walk  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_hw    <= w_hw_nxt;
      r_fm    <= w_fm_nxt;
      r_walk  <= w_walk_nxt;
      if (w_next_state != r_state)
        r_timer <= f_dwell(w_next_state);
      else if (!w_expired)
        r_timer <= r_timer - CNT_W'(1);
    end
  end

  // Pedestrian request latch: presses during the walk itself are ignored,
  // and a press on the edge that enters the walk still registers.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ped_wait <= 1'b0;
    else if (r_state != S_PW && bus.ped_req)
      r_ped_wait <= 1'b1;
    else if (r_state != S_PW && w_next_state == S_PW)
      r_ped_wait <= 1'b0;
  end

  assign bus.light_highway = r_hw;
  assign bus.light_farm    = r_fm;
  assign bus.ped_walk      = r_walk;
  assign bus.ped_wait      = r_ped_wait;
  assign bus.phase         = r_state;

endmodule

// File: tb/tb_iiitb_tlc_phase_sched.sv
// Bench for the intersection phase scheduler. Edge 0 is the last reset edge;
// a record for edge k drives inputs just after edge k and, when it checks,
// queues the state expected to be visible after edge k.
module tb_iiitb_tlc_phase_sched;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  iiitb_tlc_phase_sched_if bus_if ();

  iiitb_tlc_phase_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    int         sc;
    int         ed;
    logic       s;
    logic       p;
    logic       em;
    logic       r;
    logic       chk;
    logic [2:0] ph;
    logic       wk;
    logic       wt;
  } vec_t;

  typedef struct {
    int         sc;
    int         ed;
    logic [2:0] ph;
    logic       wk;
    logic       wt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input int sc, input int ed, input logic s, input logic p,
                     input logic em, input logic r, input logic c,
                     input logic [2:0] ph, input logic wk, input logic wt);
    vec_t v;
    v.sc = sc; v.ed = ed; v.s = s; v.p = p; v.em = em; v.r = r;
    v.chk = c; v.ph = ph; v.wk = wk; v.wt = wt;
    vecs.push_back(v);
  endtask

  function automatic logic [2:0] hw_of(input logic [2:0] ph);
    case (ph)
      3'd0:    hw_of = 3'b001;
      3'd1:    hw_of = 3'b010;
      default: hw_of = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] fm_of(input logic [2:0] ph);
    case (ph)
      3'd3:    fm_of = 3'b001;
      3'd4:    fm_of = 3'b010;
      default: fm_of = 3'b100;
    endcase
  endfunction

  task automatic cmp(input string nm, input int sc, input int ed,
                     input logic [2:0] act, input logic [2:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s sc%0d edge%0d: got %b want %b", nm, sc, ed, act, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int last;
    exp_t x;

    rst_n = 1'b0;
    bus_if.sensor  = 1'b0;
    bus_if.ped_req = 1'b0;
    bus_if.emerg   = 1'b0;

    //  sc ed  s  p  em r  chk ph wk wt
    // 1: reset values, then a farm-road service
    add(1,  0, 1, 0, 0, 1, 1, 0, 0, 0);
    add(1, 19, 1, 0, 0, 1, 1, 0, 0, 0);
    add(1, 20, 1, 0, 0, 1, 1, 1, 0, 0);
    add(1, 23, 1, 0, 0, 1, 1, 1, 0, 0);
    add(1, 24, 1, 0, 0, 1, 1, 2, 0, 0);
    add(1, 25, 1, 0, 0, 1, 1, 2, 0, 0);
    add(1, 26, 1, 0, 0, 1, 1, 3, 0, 0);
    add(1, 37, 1, 0, 0, 1, 1, 3, 0, 0);
    add(1, 38, 0, 0, 0, 1, 1, 4, 0, 0);
    add(1, 41, 0, 0, 0, 1, 1, 4, 0, 0);
    add(1, 42, 0, 0, 0, 1, 1, 6, 0, 0);
    add(1, 43, 0, 0, 0, 1, 1, 6, 0, 0);
    add(1, 44, 0, 0, 0, 1, 1, 0, 0, 0);
    add(1, 70, 0, 0, 0, 1, 1, 0, 0, 0);
    // 2: pedestrian pulse, press during walk ignored
    add(2,  0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(2,  5, 0, 1, 0, 1, 1, 0, 0, 0);
    add(2,  6, 0, 0, 0, 1, 1, 0, 0, 1);
    add(2, 19, 0, 0, 0, 1, 1, 0, 0, 1);
    add(2, 20, 0, 0, 0, 1, 1, 1, 0, 1);
    add(2, 24, 0, 0, 0, 1, 1, 2, 0, 1);
    add(2, 26, 0, 0, 0, 1, 1, 5, 1, 0);
    add(2, 27, 0, 1, 0, 1, 1, 5, 1, 0);
    add(2, 28, 0, 0, 0, 1, 1, 5, 1, 0);
    add(2, 35, 0, 0, 0, 1, 1, 5, 1, 0);
    add(2, 36, 0, 0, 0, 1, 1, 6, 0, 0);
    add(2, 38, 0, 0, 0, 1, 1, 0, 0, 0);
    add(2, 60, 0, 0, 0, 1, 1, 0, 0, 0);
    // 3: round robin, farm first then pedestrian
    add(3,  0, 1, 1, 0, 1, 1, 0, 0, 0);
    add(3,  1, 1, 0, 0, 1, 1, 0, 0, 1);
    add(3, 20, 1, 0, 0, 1, 1, 1, 0, 1);
    add(3, 26, 1, 0, 0, 1, 1, 3, 0, 1);
    add(3, 38, 1, 0, 0, 1, 1, 4, 0, 1);
    add(3, 42, 1, 0, 0, 1, 1, 6, 0, 1);
    add(3, 44, 1, 0, 0, 1, 1, 0, 0, 1);
    add(3, 63, 1, 0, 0, 1, 1, 0, 0, 1);
    add(3, 64, 1, 0, 0, 1, 1, 1, 0, 1);
    add(3, 68, 1, 0, 0, 1, 1, 2, 0, 1);
    add(3, 70, 0, 0, 0, 1, 1, 5, 1, 0);
    add(3, 80, 0, 0, 0, 1, 1, 6, 0, 0);
    add(3, 82, 0, 0, 0, 1, 1, 0, 0, 0);
    add(3,102, 0, 0, 0, 1, 1, 0, 0, 0);
    // 4: emergency cuts farm green, holds HG, aborts at AR_A
    add(4,  0, 1, 0, 0, 1, 1, 0, 0, 0);
    add(4, 26, 1, 0, 0, 1, 1, 3, 0, 0);
    add(4, 30, 1, 0, 1, 1, 1, 3, 0, 0);
    add(4, 31, 1, 0, 1, 1, 1, 4, 0, 0);
    add(4, 35, 1, 0, 1, 1, 1, 6, 0, 0);
    add(4, 37, 1, 0, 1, 1, 1, 0, 0, 0);
    add(4, 60, 1, 0, 1, 1, 1, 0, 0, 0);
    add(4, 70, 1, 0, 0, 1, 1, 0, 0, 0);
    add(4, 71, 1, 0, 0, 1, 1, 1, 0, 0);
    add(4, 75, 1, 0, 1, 1, 1, 2, 0, 0);
    add(4, 77, 1, 0, 0, 1, 1, 0, 0, 0);
    add(4, 96, 1, 0, 0, 1, 1, 0, 0, 0);
    add(4, 97, 1, 0, 0, 1, 1, 1, 0, 0);
    // 5: press on the PW-entry edge survives; reset mid-walk
    add(5,  0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(5,  5, 0, 1, 0, 1, 1, 0, 0, 0);
    add(5,  6, 0, 0, 0, 1, 1, 0, 0, 1);
    add(5, 25, 0, 1, 0, 1, 1, 2, 0, 1);
    add(5, 26, 0, 0, 0, 1, 1, 5, 1, 1);
    add(5, 30, 0, 0, 0, 0, 1, 5, 1, 1);
    add(5, 31, 0, 0, 0, 1, 1, 0, 0, 0);
    add(5, 40, 0, 0, 0, 1, 1, 0, 0, 0);
    add(5, 60, 0, 0, 0, 1, 1, 0, 0, 0);

    idx = 0;
    for (int sc = 1; sc <= 5; sc++) begin
      last = 0;
      foreach (vecs[i]) if (vecs[i].sc == sc && vecs[i].ed > last) last = vecs[i].ed;

      rst_n = 1'b0;
      bus_if.sensor  = 1'b0;
      bus_if.ped_req = 1'b0;
      bus_if.emerg   = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      for (int e = 0; e <= last; e++) begin
        if (e > 0) begin
          @(posedge clk);
          #1;
        end
        while (idx < vecs.size() && vecs[idx].sc == sc && vecs[idx].ed == e) begin
          if (vecs[idx].chk) begin
            x.sc = sc; x.ed = e; x.ph = vecs[idx].ph;
            x.wk = vecs[idx].wk; x.wt = vecs[idx].wt;
            sb.push_back(x);
          end
          bus_if.sensor  = vecs[idx].s;
          bus_if.ped_req = vecs[idx].p;
          bus_if.emerg   = vecs[idx].em;
          rst_n          = vecs[idx].r;
          idx++;
        end
        @(negedge clk);
        total++;
        if (bus_if.light_highway != 3'b100 && bus_if.light_farm != 3'b100) begin
          bad++;
          $display("FAIL conflict sc%0d edge%0d: hw=%b fm=%b both non-red",
                   sc, e, bus_if.light_highway, bus_if.light_farm);
        end
        while (sb.size() > 0) begin
          x = sb.pop_front();
          cmp("phase", x.sc, x.ed, bus_if.phase, x.ph);
          cmp("hw", x.sc, x.ed, bus_if.light_highway, hw_of(x.ph));
          cmp("fm", x.sc, x.ed, bus_if.light_farm, fm_of(x.ph));
          cmp("walk", x.sc, x.ed, {2'b00, bus_if.ped_walk}, {2'b00, x.wk});
          cmp("wait", x.sc, x.ed, {2'b00, bus_if.ped_wait}, {2'b00, x.wt});
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
